// File: rtl/adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_sequencer
// Purpose  : Round-robin ADC channel scanner with a 4-deep sample FIFO
//            towards the CPU, drop counter and sticky response timeout.
// Revision : 1.0  initial release
// ============================================================================
module adc_sequencer #(
    parameter int FIRST_CHANNEL = 1,
    parameter int NUM_CHANNELS  = 4,
    parameter int TIMEOUT       = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_in,
    output logic        command_valid_out,
    output logic [4:0]  command_channel_out,
    output logic        command_startofpacket_out,
    output logic        command_endofpacket_out,
    input  logic        command_ready_in,
    input  logic        response_valid_in,
    input  logic [4:0]  response_channel_in,
    input  logic [11:0] response_data_in,
    output logic [31:0] adc_out,
    output logic        adc_stb_out,
    input  logic        adc_ack_in,
    output logic [7:0]  overflow_count_out,
    output logic        timeout_out
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NUM_CHANNELS - 1);
    localparam logic [4:0]    CH_BASE  = 5'(FIRST_CHANNEL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      index_q, index_d;
    logic [7:0]      seq_q, seq_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            timeout_q, timeout_d;
    logic [3:0][31:0] fifo_q, fifo_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic [7:0]      ovf_q, ovf_d;

    logic [4:0]  cur_channel;
    logic        complete;
    logic        expire;
    logic        fifo_full;
    logic        pop;
    logic        push_ok;
    logic [31:0] word;

    assign cur_channel = CH_BASE + {2'b00, index_q};
    assign complete    = (state_q == ST_WAIT) && response_valid_in
                         && (response_channel_in == cur_channel);
    assign expire      = (state_q == ST_WAIT) && !complete && (tcnt_q == TO_LAST);
    assign fifo_full   = (count_q == 3'd4);
    assign pop         = (count_q != 3'd0) && adc_ack_in;
    // A full FIFO still takes the new word when the head leaves in the same cycle.
    assign push_ok     = complete && (!fifo_full || pop);
    assign word        = {seq_q, 3'b000, cur_channel, 4'b0000, response_data_in};

    always_comb begin
        state_d                   = state_q;
        index_d                   = index_q;
        seq_d                     = seq_q;
        tcnt_d                    = tcnt_q;
        timeout_d                 = timeout_q;
        command_valid_out         = 1'b0;
        command_startofpacket_out = 1'b0;
        command_endofpacket_out   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_in) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                command_valid_out         = 1'b1;
                command_startofpacket_out = 1'b1;
                command_endofpacket_out   = 1'b1;
                if (command_ready_in) begin
                    state_d = ST_WAIT;
                    tcnt_d  = '0;
                end
            end
            ST_WAIT: begin
                tcnt_d = tcnt_q + TW'(1);
                if (complete || expire) begin
                    index_d = (index_q == IDX_LAST) ? 3'd0 : index_q + 3'd1;
                    state_d = enable_in ? ST_ISSUE : ST_IDLE;
                end
                if (complete) begin
                    seq_d = seq_q + 8'd1;
                end else if (expire) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            fifo_d[wr_ptr_q] = word;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (complete && !push_ok && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            index_q   <= 3'd0;
            seq_q     <= 8'd0;
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
            fifo_q    <= '0;
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            ovf_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            seq_q     <= seq_d;
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign command_channel_out = cur_channel;
    assign adc_stb_out         = (count_q != 3'd0);
    assign adc_out             = adc_stb_out ? fifo_q[rd_ptr_q] : 32'h0;
    assign overflow_count_out  = ovf_q;
    assign timeout_out         = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sequencer
// Purpose  : Directed self-checking bench for adc_sequencer with an ADC model.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_in = 1'b0;
    logic        command_ready_in = 1'b0;
    logic        response_valid_in = 1'b0;
    logic [4:0]  response_channel_in = 5'd0;
    logic [11:0] response_data_in = 12'd0;
    logic        adc_ack_in = 1'b0;
    logic        command_valid_out;
    logic [4:0]  command_channel_out;
    logic        command_startofpacket_out;
    logic        command_endofpacket_out;
    logic [31:0] adc_out;
    logic        adc_stb_out;
    logic [7:0]  overflow_count_out;
    logic        timeout_out;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int resp_edge_cyc = 0;
    int resp_delay = 3;
    logic       inject_bad = 1'b0;
    logic [4:0] drop_ch = 5'd31;
    logic [4:0] resp_ch;

    adc_sequencer #(
        .FIRST_CHANNEL (1),
        .NUM_CHANNELS  (4),
        .TIMEOUT       (16)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .enable_in                 (enable_in),
        .command_valid_out         (command_valid_out),
        .command_channel_out       (command_channel_out),
        .command_startofpacket_out (command_startofpacket_out),
        .command_endofpacket_out   (command_endofpacket_out),
        .command_ready_in          (command_ready_in),
        .response_valid_in         (response_valid_in),
        .response_channel_in       (response_channel_in),
        .response_data_in          (response_data_in),
        .adc_out                   (adc_out),
        .adc_stb_out               (adc_stb_out),
        .adc_ack_in                (adc_ack_in),
        .overflow_count_out        (overflow_count_out),
        .timeout_out               (timeout_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: answers resp_delay cycles after the accepting edge with 0x100+channel.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && command_valid_out && command_ready_in) begin
                resp_ch = command_channel_out;
                @(posedge clk);
                for (int k = 1; k <= resp_delay; k++) begin
                    #1;
                    if (k == resp_delay && resp_ch != drop_ch) begin
                        response_valid_in   = 1'b1;
                        response_channel_in = resp_ch;
                        response_data_in    = 12'h100 + {7'b0, resp_ch};
                    end else if (k == 1 && inject_bad) begin
                        response_valid_in   = 1'b1;
                        response_channel_in = 5'd7;
                        response_data_in    = 12'hABC;
                    end else begin
                        response_valid_in = 1'b0;
                    end
                    @(posedge clk);
                    if (k == resp_delay) resp_edge_cyc = cyc;
                end
                #1 response_valid_in = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable_in = 1'b0;
        adc_ack_in = 1'b1;
        command_ready_in = 1'b1;
        repeat (6) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_word(output logic got);
        int n = 0;
        do begin
            step();
            n++;
        end while (!adc_stb_out && n < 40);
        got = adc_stb_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable_in = 1'b1;
        command_ready_in = 1'b0;
        adc_ack_in = 1'b0;
        repeat (2) step();
        checks++; if (command_valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", command_valid_out); else passes++;
        checks++; if (command_startofpacket_out !== 1'b0) $display("FAIL reset_sop: got %b expected 0", command_startofpacket_out); else passes++;
        checks++; if (command_endofpacket_out !== 1'b0) $display("FAIL reset_eop: got %b expected 0", command_endofpacket_out); else passes++;
        checks++; if (command_channel_out !== 5'd1) $display("FAIL reset_channel: got %0d expected 1", command_channel_out); else passes++;
        checks++; if (adc_out !== 32'h0) $display("FAIL reset_adc_out: got %h expected 0", adc_out); else passes++;
        checks++; if (adc_stb_out !== 1'b0) $display("FAIL reset_stb: got %b expected 0", adc_stb_out); else passes++;
        checks++; if (overflow_count_out !== 8'd0) $display("FAIL reset_overflow: got %0d expected 0", overflow_count_out); else passes++;
        checks++; if (timeout_out !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout_out); else passes++;
        enable_in = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        checks++; if (command_valid_out !== 1'b0) $display("FAIL idle_hold: valid got %b expected 0", command_valid_out); else passes++;
    endtask

    task automatic test_basic_scan();
        logic [31:0] exp_w [5];
        logic got;
        exp_w = '{32'h00010101, 32'h01020102, 32'h02030103, 32'h03040104, 32'h04010101};
        do_reset();
        enable_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_word(got);
            checks++;
            if (!got) $display("FAIL basic_word%0d: no strobe, expected %h", i, exp_w[i]);
            else if (adc_out !== exp_w[i]) $display("FAIL basic_word%0d: got %h expected %h", i, adc_out, exp_w[i]);
            else passes++;
            if (i == 0) begin
                checks++;
                if (cyc !== resp_edge_cyc + 1) $display("FAIL basic_latency: strobe at cycle %0d expected %0d", cyc, resp_edge_cyc + 1);
                else passes++;
            end
        end
        enable_in = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [4];
        logic held_ok = 1'b1;
        logic got;
        int n = 0;
        exp_w = '{32'h01020102, 32'h02030103, 32'h03040104, 32'h06030103};
        do_reset();
        adc_ack_in = 1'b0;
        enable_in = 1'b1;
        while (overflow_count_out !== 8'd2 && n < 100) begin
            step();
            n++;
            if (adc_stb_out && adc_out !== 32'h00010101) held_ok = 1'b0;
        end
        checks++; if (overflow_count_out !== 8'd2) $display("FAIL bp_overflow: got %0d expected 2", overflow_count_out); else passes++;
        checks++; if (held_ok !== 1'b1) $display("FAIL bp_hold: head word changed while not acked, now %h", adc_out); else passes++;
        checks++; if (adc_stb_out !== 1'b1) $display("FAIL bp_stb: got %b expected 1", adc_stb_out); else passes++;
        checks++; if (adc_out !== 32'h00010101) $display("FAIL bp_head: got %h expected 00010101", adc_out); else passes++;
        adc_ack_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_word(got);
            checks++;
            if (!got) $display("FAIL bp_drain%0d: no strobe, expected %h", i, exp_w[i]);
            else if (adc_out !== exp_w[i]) $display("FAIL bp_drain%0d: got %h expected %h", i, adc_out, exp_w[i]);
            else passes++;
        end
        checks++; if (overflow_count_out !== 8'd2) $display("FAIL bp_overflow_final: got %0d expected 2", overflow_count_out); else passes++;
        enable_in = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_timeout();
        logic got;
        int n = 0;
        int stb_seen = 0;
        do_reset();
        drop_ch = 5'd2;
        enable_in = 1'b1;
        wait_word(got);
        checks++; if (!got || adc_out !== 32'h00010101) $display("FAIL to_first_word: got %h expected 00010101", adc_out); else passes++;
        while (!(command_valid_out && command_channel_out == 5'd2) && n < 30) begin
            step();
            n++;
        end
        checks++; if (!(command_valid_out && command_channel_out == 5'd2)) $display("FAIL to_issue_ch2: channel %0d valid %b expected channel 2 valid 1", command_channel_out, command_valid_out); else passes++;
        repeat (16) begin
            step();
            if (adc_stb_out) stb_seen++;
        end
        checks++; if (timeout_out !== 1'b0) $display("FAIL to_early: got %b expected 0 at 15 cycles", timeout_out); else passes++;
        step();
        checks++; if (timeout_out !== 1'b1) $display("FAIL to_flag: got %b expected 1 at 16 cycles", timeout_out); else passes++;
        checks++; if (command_valid_out !== 1'b1 || command_channel_out !== 5'd3) $display("FAIL to_next_issue: valid %b channel %0d expected valid 1 channel 3", command_valid_out, command_channel_out); else passes++;
        wait_word(got);
        checks++; if (!got || adc_out[23:0] !== 24'h030103) $display("FAIL to_next_word: got %h expected xx030103", adc_out); else passes++;
        checks++; if (stb_seen !== 0) $display("FAIL to_no_word: got %0d words expected 0", stb_seen); else passes++;
        drop_ch = 5'd31;
        enable_in = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_ready_stall();
        logic stall_ok = 1'b1;
        logic [31:0] last_w = 32'h0;
        int accepts = 0;
        int words = 0;
        do_reset();
        command_ready_in = 1'b0;
        enable_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!(command_valid_out && command_startofpacket_out && command_endofpacket_out && command_channel_out == 5'd1))
                stall_ok = 1'b0;
        end
        checks++; if (stall_ok !== 1'b1) $display("FAIL stall_stable: valid %b channel %0d expected valid 1 channel 1", command_valid_out, command_channel_out); else passes++;
        command_ready_in = 1'b1;
        enable_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (command_valid_out && command_ready_in) accepts++;
            if (adc_stb_out) begin
                words++;
                last_w = adc_out;
            end
            step();
        end
        checks++; if (accepts !== 1) $display("FAIL stall_accepts: got %0d expected 1", accepts); else passes++;
        checks++; if (words !== 1) $display("FAIL stall_words: got %0d expected 1", words); else passes++;
        checks++; if (last_w !== 32'h00010101) $display("FAIL stall_word: got %h expected 00010101", last_w); else passes++;
    endtask

    task automatic test_mismatch_enable();
        logic got;
        logic [31:0] last_w = 32'h0;
        int n = 0;
        int words = 0;
        int valids = 0;
        do_reset();
        inject_bad = 1'b1;
        enable_in = 1'b1;
        wait_word(got);
        checks++; if (!got || adc_out !== 32'h00010101) $display("FAIL mm_word: got %h expected 00010101", adc_out); else passes++;
        while (!(command_valid_out && command_channel_out == 5'd2) && n < 30) begin
            step();
            n++;
        end
        step();
        checks++; if (command_valid_out !== 1'b0) $display("FAIL mm_wait: valid got %b expected 0", command_valid_out); else passes++;
        enable_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (command_valid_out) valids++;
            if (adc_stb_out) begin
                words++;
                last_w = adc_out;
            end
        end
        checks++; if (words !== 1) $display("FAIL en_words: got %0d expected 1", words); else passes++;
        checks++; if (last_w !== 32'h01020102) $display("FAIL en_word: got %h expected 01020102", last_w); else passes++;
        checks++; if (valids !== 0) $display("FAIL en_idle: valid cycles got %0d expected 0", valids); else passes++;
        inject_bad = 1'b0;
    endtask

    task automatic test_reset_midwait();
        logic got;
        int n = 0;
        int stray = 0;
        do_reset();
        resp_delay = 4;
        enable_in = 1'b1;
        while (!(command_valid_out && command_channel_out == 5'd1) && n < 30) begin
            step();
            n++;
        end
        step();
        rst_n = 1'b0;
        enable_in = 1'b0;
        step();
        checks++; if ({command_valid_out, command_startofpacket_out, command_endofpacket_out, command_channel_out} !== 8'b000_00001)
            $display("FAIL rmw_cmd: got %b expected 00000001", {command_valid_out, command_startofpacket_out, command_endofpacket_out, command_channel_out}); else passes++;
        checks++; if ({adc_stb_out, adc_out} !== 33'h0) $display("FAIL rmw_stream: stb %b data %h expected 0 0", adc_stb_out, adc_out); else passes++;
        checks++; if ({overflow_count_out, timeout_out} !== 9'h0) $display("FAIL rmw_status: overflow %0d timeout %b expected 0 0", overflow_count_out, timeout_out); else passes++;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (adc_stb_out || command_valid_out) stray++;
        end
        checks++; if (stray !== 0) $display("FAIL rmw_late_resp: activity cycles got %0d expected 0", stray); else passes++;
        resp_delay = 3;
        enable_in = 1'b1;
        step();
        checks++; if (command_valid_out !== 1'b1 || command_channel_out !== 5'd1) $display("FAIL rmw_restart: valid %b channel %0d expected valid 1 channel 1", command_valid_out, command_channel_out); else passes++;
        wait_word(got);
        checks++; if (!got || adc_out !== 32'h00010101) $display("FAIL rmw_word: got %h expected 00010101", adc_out); else passes++;
        enable_in = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_timeout();
        test_ready_stall();
        test_mismatch_enable();
        test_reset_midwait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
